palette_fade_ctrl: RTL and testbench

- Sequences frame-synchronous brightness fades on the 16-entry, 4-bit-per-channel background palette lookup.
- Drives the palette index from the pixel stream and takes the combinational RGB result back.
- Scales each channel by a fade level, and outputs a registered, faded pixel to the VGA colour path.
- Level changes only at frame boundaries, so no frame is drawn with mixed brightness.

---
 rtl/palette_fade_pkg.sv | 19 +
 rtl/pal_scale.sv | 18 +
 rtl/palette_fade_ctrl.sv | 133 +++++++++++++
 tb/tb_palette_fade_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/palette_fade_pkg.sv
// Shared types and constants for the palette fade controller.
package palette_fade_pkg;

  localparam int LEVEL_W   = 5;
  localparam int LEVEL_MAX = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FADING = 2'd1,
    FINISH = 2'd2
  } fade_state_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/pal_scale.sv
// One colour channel scaled by the fade level: (c * level) >> 4, combinational.
module pal_scale
  import palette_fade_pkg::*;
(
  input  logic [3:0]         c,
  input  logic [LEVEL_W-1:0] level,
  output logic [3:0]         y
);

  logic [8:0] prod;
  logic       unused_prod;

  assign prod = {5'd0, c} * {4'd0, level};
  // Level 16 puts c exactly into [7:4]; bit 8 can never be set with level <= 16.
  assign y           = prod[7:4];
  assign unused_prod = ^{prod[8], prod[3:0]};

endmodule

// File: rtl/palette_fade_ctrl.sv
// Frame-synchronous palette fade: level FSM plus a 2-stage scaled pixel path.
// Optional macro PALETTE_FADE_REVERSE_EN lets an opposite-direction request reverse a running fade.
module palette_fade_ctrl #(
  parameter int FRAMES_PER_STEP = 4,
  parameter int LEVEL_MAX       = palette_fade_pkg::LEVEL_MAX
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_start,
  input  logic       fade_req,
  input  logic       fade_dir,
  output logic       busy,
  output logic       done,
  output logic [4:0] level,
  input  logic       pix_valid_in,
  input  logic [3:0] index_in,
  output logic [3:0] pal_index,
  input  logic [3:0] pal_red,
  input  logic [3:0] pal_green,
  input  logic [3:0] pal_blue,
  output logic       pix_valid_out,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  import palette_fade_pkg::*;

  localparam int                 STAGES   = 2;
  localparam logic [LEVEL_W-1:0] LVL_TOP  = LEVEL_W'(LEVEL_MAX);
  localparam logic [7:0]         CNT_LAST = 8'(FRAMES_PER_STEP - 1);

  fade_state_t        state, state_n;
  logic [LEVEL_W-1:0] level_q, level_n;
  logic [7:0]         cnt, cnt_n;
  logic               dir, dir_n;
  logic [LEVEL_W-1:0] tgt, req_tgt;

  assign tgt     = dir      ? '0 : LVL_TOP;
  assign req_tgt = fade_dir ? '0 : LVL_TOP;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      level_q <= LVL_TOP;
      cnt     <= '0;
      dir     <= 1'b0;
    end else begin
      state   <= state_n;
      level_q <= level_n;
      cnt     <= cnt_n;
      dir     <= dir_n;
    end
  end

  always_comb begin
    state_n = state;
    level_n = level_q;
    cnt_n   = cnt;
    dir_n   = dir;
    case (state)
      IDLE: begin
        if (fade_req) begin
          dir_n   = fade_dir;
          cnt_n   = '0;
          state_n = (level_q == req_tgt) ? FINISH : FADING;
        end
      end
      FADING: begin
`ifdef PALETTE_FADE_REVERSE_EN
        if (fade_req && (fade_dir != dir)) begin
          dir_n = fade_dir;
          cnt_n = '0;
          if (level_q == req_tgt) state_n = FINISH;
        end else
`endif
        if (frame_start) begin
          if (cnt == CNT_LAST) begin
            cnt_n = '0;
            // Guarded step keeps level saturated at either end.
            if (level_q != tgt) level_n = dir ? level_q - 1'b1 : level_q + 1'b1;
            if (level_n == tgt) state_n = FINISH;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state == FADING);
  assign done      = (state == FINISH);
  assign level     = level_q;
  assign pal_index = index_in;

  // Pixel path: stage 1 captures palette RGB + level, stage 2 holds the scaled colour.
  logic [STAGES:1]    vld_pipe;
  rgb444_t            s1_rgb, s2_rgb;
  logic [LEVEL_W-1:0] s1_lvl;
  logic [2:0][3:0]    s1_c, sc;

  assign s1_c = s1_rgb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      s1_rgb   <= '0;
      s1_lvl   <= '0;
      s2_rgb   <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], pix_valid_in};
      s1_rgb   <= pix_valid_in ? rgb444_t'({pal_red, pal_green, pal_blue}) : '0;
      s1_lvl   <= level_q;
      s2_rgb   <= vld_pipe[1] ? rgb444_t'(sc) : '0;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    pal_scale u_scale (
      .c     (s1_c[ch]),
      .level (s1_lvl),
      .y     (sc[ch])
    );
  end

  assign pix_valid_out = vld_pipe[STAGES];
  assign red           = s2_rgb.r;
  assign green         = s2_rgb.g;
  assign blue          = s2_rgb.b;

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Self-checking bench: directed fade scenarios plus random traffic against a behavioural model.
module tb_palette_fade_ctrl;

  localparam int FPS  = 4;
  localparam int LMAX = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_start = 1'b0, fade_req = 1'b0, fade_dir = 1'b0;
  logic       busy, done;
  logic [4:0] level;
  logic       pix_valid_in = 1'b0;
  logic [3:0] index_in = '0;
  logic [3:0] pal_index, pal_red, pal_green, pal_blue;
  logic       pix_valid_out;
  logic [3:0] red, green, blue;

  logic [3:0] pr[16], pg[16], pb[16];

  int compared = 0, mismatched = 0, done_cnt = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  assign pal_red   = pr[pal_index];
  assign pal_green = pg[pal_index];
  assign pal_blue  = pb[pal_index];

  palette_fade_ctrl #(.FRAMES_PER_STEP(FPS), .LEVEL_MAX(LMAX)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .fade_req(fade_req),
    .fade_dir(fade_dir), .busy(busy), .done(done), .level(level),
    .pix_valid_in(pix_valid_in), .index_in(index_in), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .pix_valid_out(pix_valid_out), .red(red), .green(green), .blue(blue)
  );

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: level in plain integers, pixels as a 2-entry delay line.
  int m_lvl = LMAX, m_frames = 0;
  bit m_fading = 0, m_done = 0, m_dir = 0;
  int m1[4] = '{0, 0, 0, 0};
  int m2[4] = '{0, 0, 0, 0};

  function automatic int tgt(input bit d);
    return d ? 0 : LMAX;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_lvl = LMAX; m_frames = 0; m_fading = 0; m_done = 0; m_dir = 0;
      m1 = '{0, 0, 0, 0};
      m2 = '{0, 0, 0, 0};
    end else begin
      m2 = m1;
      m1[0] = pix_valid_in;
      m1[1] = pix_valid_in ? pr[index_in] * m_lvl / 16 : 0;
      m1[2] = pix_valid_in ? pg[index_in] * m_lvl / 16 : 0;
      m1[3] = pix_valid_in ? pb[index_in] * m_lvl / 16 : 0;
      if (m_done) m_done = 0;
      else if (m_fading) begin
`ifdef PALETTE_FADE_REVERSE_EN
        if (fade_req && fade_dir != m_dir) begin
          m_dir = fade_dir; m_frames = 0;
          if (m_lvl == tgt(m_dir)) begin m_fading = 0; m_done = 1; end
        end else
`endif
        if (frame_start) begin
          m_frames++;
          if (m_frames == FPS) begin
            m_frames = 0;
            m_lvl += m_dir ? -1 : 1;
            if (m_lvl == tgt(m_dir)) begin m_fading = 0; m_done = 1; end
          end
        end
      end else if (fade_req) begin
        m_dir = fade_dir; m_frames = 0;
        if (m_lvl == tgt(m_dir)) m_done = 1;
        else m_fading = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && done) done_cnt++;
    if (chk_on) begin
      chk("busy", busy, m_fading);
      chk("done", done, m_done);
      chk("level", level, m_lvl);
      chk("pal_index", pal_index, index_in);
      chk("pix_valid_out", pix_valid_out, m2[0]);
      chk("red", red, m2[1]);
      chk("green", green, m2[2]);
      chk("blue", blue, m2[3]);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic frame();
    frame_start = 1; tick(); frame_start = 0; tick(2);
  endtask

  task automatic req(input bit d);
    fade_req = 1; fade_dir = d; tick(); fade_req = 0;
  endtask

  task automatic pix(input bit v, input int idx);
    pix_valid_in = v; index_in = 4'(idx); tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin pr[i] = 4'(i); pg[i] = 4'(15 - i); pb[i] = 4'(i ^ 5); end
    tick(3);
    chk_on = 1;
    chk("reset_level", level, 16);
    chk("reset_busy", busy, 0);
    chk("reset_red", red, 0);
    chk("reset_vout", pix_valid_out, 0);
    reset_n = 1; tick();

    // Full brightness pass-through with two-cycle latency.
    pr[5] = 4'hE; pg[5] = 4'hD; pb[5] = 4'hE;
    pix(1, 5);
    pix_valid_in = 0; index_in = 0;
    chk("lat_1cyc_vout", pix_valid_out, 0);
    tick();
    chk("full_red", red, 14); chk("full_green", green, 13); chk("full_blue", blue, 14);
    chk("full_vout", pix_valid_out, 1); chk("full_level", level, 16); chk("full_busy", busy, 0);

    // Fade out: one step per 4 frames, 64 frames to black.
    req(1);
    chk("fadeout_busy", busy, 1);
    repeat (3) frame();
    chk("lvl_after3", level, 16);
    frame();
    chk("lvl_after4", level, 15);
    repeat (60) frame();
    chk("fadeout_level", level, 0);
    chk("fadeout_busy_end", busy, 0);
    chk("fadeout_done_cnt", done_cnt, 1);
    pix(1, 5); pix(0, 0);
    chk("black_red", red, 0); chk("black_green", green, 0); chk("black_blue", blue, 0);
    chk("black_vout", pix_valid_out, 1);

    // Fade in to level 8, then mixed pixels with a valid gap.
    req(0);
    repeat (32) frame();
    chk("half_level", level, 8);
    pr[3] = 4'hB; pg[3] = 4'hB; pb[3] = 4'hD;
    pix(1, 3); pix(0, 3);
    chk("half_red", red, 5); chk("half_green", green, 5); chk("half_blue", blue, 6);
    pix(1, 5); pix(1, 3); pix(0, 9); pix(1, 7); pix(0, 0);
    tick(2);
    repeat (32) frame();
    chk("fadein_level", level, 16);
    chk("fadein_done_cnt", done_cnt, 2);

    // Request toward the level already held: immediate done, no busy.
    req(0);
    chk("attgt_done", done, 1); chk("attgt_busy", busy, 0); chk("attgt_level", level, 16);
    tick();
    chk("attgt_done_clr", done, 0);
    chk("attgt_done_cnt", done_cnt, 3);

    // Opposite request mid-fade at level 10.
    req(1);
    repeat (24) frame();
    chk("mid_level", level, 10);
    req(0);
    repeat (4) frame();
`ifdef PALETTE_FADE_REVERSE_EN
    chk("mid_after", level, 11);
`else
    chk("mid_after", level, 9);
`endif
    for (int i = 0; i < 200 && busy; i++) frame();
    chk("mid_end_busy", busy, 0);
    chk("mid_done_cnt", done_cnt, 4);
`ifdef PALETTE_FADE_REVERSE_EN
    chk("mid_end_level", level, 16);
    req(1);
    repeat (36) frame();
`else
    chk("mid_end_level", level, 0);
    req(0);
    repeat (28) frame();
`endif

    // Asynchronous reset mid-fade with pixels in flight.
    chk("pre_rst_level", level, 7);
    pix_valid_in = 1; index_in = 5; tick(2);
    #3 reset_n = 0;
    #1;
    chk("rst_level", level, 16); chk("rst_busy", busy, 0);
    chk("rst_red", red, 0); chk("rst_vout", pix_valid_out, 0); chk("rst_done", done, 0);
    tick(2);
    reset_n = 1; pix_valid_in = 0;
    tick(2);
    chk("rst_done_cnt", done_cnt, 4);

    // Random traffic against the model.
    for (int i = 0; i < 16; i++) begin
      pr[i] = 4'($urandom); pg[i] = 4'($urandom); pb[i] = 4'($urandom);
    end
    for (int i = 0; i < 5000; i++) begin
      frame_start  = ($urandom % 4) == 0;
      fade_req     = ($urandom % 40) == 0;
      fade_dir     = 1'($urandom);
      pix_valid_in = 1'($urandom);
      index_in     = 4'($urandom);
      reset_n      = ($urandom % 1500) != 0;
      tick();
    end
    reset_n = 1; frame_start = 0; fade_req = 0; pix_valid_in = 0;
    tick(2);
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
